// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/control unit.
package pipe_ctrl_pkg;

  localparam logic [1:0] FWD_EX_MEM = 2'd0;
  localparam logic [1:0] FWD_MEM_WB = 2'd1;
  localparam logic [1:0] FWD_REG    = 2'd2;

  typedef enum logic {
    ST_IDLE,
    ST_BUSY
  } state_t;

endpackage

// File: rtl/pipe_hazard_ctrl_fwd_sel.sv
// Per-operand forward selector: picks EX/MEM, MEM/WB or register-file data.
module fwd_sel
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] src,
  input  logic                  src_used,
  input  logic                  mem_regwrite,
  input  logic [REG_ADDR_W-1:0] mem_wreg,
  input  logic                  wb_regwrite,
  input  logic [REG_ADDR_W-1:0] wb_wreg,
  output logic [1:0]            sel
);

  always_comb begin
    sel = FWD_REG;
    if (src_used && (src != '0)) begin
      if (mem_regwrite && (mem_wreg == src)) begin
        sel = FWD_EX_MEM;
      end else if (wb_regwrite && (wb_wreg == src)) begin
        sel = FWD_MEM_WB;
      end
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush/forward control for the 5-stage pipeline.
// Optional performance counters are built when PIPE_HAZARD_PERF_EN is defined.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int MULDIV_LAT = 4,
  parameter int CNT_W      = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [REG_ADDR_W-1:0] id_rs_i,
  input  logic [REG_ADDR_W-1:0] id_rt_i,
  input  logic                  id_uses_rs_i,
  input  logic                  id_uses_rt_i,
  input  logic [REG_ADDR_W-1:0] ex_rs_i,
  input  logic [REG_ADDR_W-1:0] ex_rt_i,
  input  logic                  ex_uses_rt_i,
  input  logic                  ex_memread_i,
  input  logic                  ex_regwrite_i,
  input  logic [REG_ADDR_W-1:0] ex_wreg_i,
  input  logic                  ex_long_i,
  input  logic                  mem_regwrite_i,
  input  logic [REG_ADDR_W-1:0] mem_wreg_i,
  input  logic                  mem_branch_taken_i,
  input  logic                  wb_regwrite_i,
  input  logic [REG_ADDR_W-1:0] wb_wreg_i,
  output logic                  pc_write_o,
  output logic                  if_id_write_o,
  output logic                  id_ex_write_o,
  output logic                  if_id_flush_o,
  output logic                  id_ex_flush_o,
  output logic                  ex_mem_flush_o,
  output logic [1:0]            forward_a_o,
  output logic [1:0]            forward_b_o,
  output logic [CNT_W-1:0]      stall_cnt_o,
  output logic [CNT_W-1:0]      flush_cnt_o
);

  localparam bit         HAS_LONG = (MULDIV_LAT > 1);
  localparam logic [3:0] RELOAD   = HAS_LONG ? 4'(MULDIV_LAT - 2) : 4'd0;

  state_t     state;
  logic [3:0] cnt;
  logic       branch;
  logic       long_start;
  logic       long_stall;
  logic       load_use;

  // Holding the selectors' "used" inputs low during reset forces FWD_REG.
  fwd_sel #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_a (
    .src          (ex_rs_i),
    .src_used     (~rst_i),
    .mem_regwrite (mem_regwrite_i),
    .mem_wreg     (mem_wreg_i),
    .wb_regwrite  (wb_regwrite_i),
    .wb_wreg      (wb_wreg_i),
    .sel          (forward_a_o)
  );

  fwd_sel #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_b (
    .src          (ex_rt_i),
    .src_used     (ex_uses_rt_i & ~rst_i),
    .mem_regwrite (mem_regwrite_i),
    .mem_wreg     (mem_wreg_i),
    .wb_regwrite  (wb_regwrite_i),
    .wb_wreg      (wb_wreg_i),
    .sel          (forward_b_o)
  );

  always_comb begin
    branch     = mem_branch_taken_i & ~rst_i;
    long_start = HAS_LONG && (state == ST_IDLE) && ex_long_i;
    long_stall = ~rst_i & ~branch & (long_start | ((state == ST_BUSY) && (cnt != 4'd0)));
    load_use   = ex_memread_i && ex_regwrite_i && (ex_wreg_i != '0) &&
                 ((id_uses_rs_i && (ex_wreg_i == id_rs_i)) ||
                  (id_uses_rt_i && (ex_wreg_i == id_rt_i)));
  end

  always_comb begin
    pc_write_o     = 1'b1;
    if_id_write_o  = 1'b1;
    id_ex_write_o  = 1'b1;
    if_id_flush_o  = 1'b0;
    id_ex_flush_o  = 1'b0;
    ex_mem_flush_o = 1'b0;
    if (rst_i) begin
      // defaults only
    end else if (branch) begin
      if_id_flush_o  = 1'b1;
      id_ex_flush_o  = 1'b1;
      ex_mem_flush_o = 1'b1;
    end else if (long_stall) begin
      pc_write_o     = 1'b0;
      if_id_write_o  = 1'b0;
      id_ex_write_o  = 1'b0;
      ex_mem_flush_o = 1'b1;
    end else if (load_use) begin
      pc_write_o    = 1'b0;
      if_id_write_o = 1'b0;
      id_ex_flush_o = 1'b1;
    end
  end

  // The first stall cycle happens in IDLE, so BUSY counts MULDIV_LAT-2 more.
  always_ff @(posedge clk_i) begin
    if (rst_i || mem_branch_taken_i) begin
      state <= ST_IDLE;
      cnt   <= 4'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (long_start) begin
            state <= ST_BUSY;
            cnt   <= RELOAD;
          end
        end
        ST_BUSY: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
          cnt   <= 4'd0;
        end
      endcase
    end
  end

`ifdef PIPE_HAZARD_PERF_EN
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (!pc_write_o && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
      if (mem_branch_taken_i && (flush_cnt != '1)) begin
        flush_cnt <= flush_cnt + 1'b1;
      end
    end
  end

  assign stall_cnt_o = stall_cnt;
  assign flush_cnt_o = flush_cnt;
`else
  assign stall_cnt_o = '0;
  assign flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomized self-checking bench for pipe_hazard_ctrl against a cycle-count reference model.
module tb_pipe_hazard_ctrl;

  localparam int RW  = 5;
  localparam int LAT = 4;
  localparam int CW  = 4;
`ifdef PIPE_HAZARD_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [RW-1:0] id_rs, id_rt, ex_rs, ex_rt, ex_wreg, mem_wreg, wb_wreg;
  logic          id_uses_rs, id_uses_rt, ex_uses_rt, ex_memread, ex_regwrite;
  logic          ex_long, mem_regwrite, mem_branch_taken, wb_regwrite;
  logic          pc_write, if_id_write, id_ex_write;
  logic          if_id_flush, id_ex_flush, ex_mem_flush;
  logic [1:0]    forward_a, forward_b;
  logic [CW-1:0] stall_cnt, flush_cnt;

  pipe_hazard_ctrl #(.REG_ADDR_W(RW), .MULDIV_LAT(LAT), .CNT_W(CW)) dut (
    .clk_i              (clk),
    .rst_i              (rst),
    .id_rs_i            (id_rs),
    .id_rt_i            (id_rt),
    .id_uses_rs_i       (id_uses_rs),
    .id_uses_rt_i       (id_uses_rt),
    .ex_rs_i            (ex_rs),
    .ex_rt_i            (ex_rt),
    .ex_uses_rt_i       (ex_uses_rt),
    .ex_memread_i       (ex_memread),
    .ex_regwrite_i      (ex_regwrite),
    .ex_wreg_i          (ex_wreg),
    .ex_long_i          (ex_long),
    .mem_regwrite_i     (mem_regwrite),
    .mem_wreg_i         (mem_wreg),
    .mem_branch_taken_i (mem_branch_taken),
    .wb_regwrite_i      (wb_regwrite),
    .wb_wreg_i          (wb_wreg),
    .pc_write_o         (pc_write),
    .if_id_write_o      (if_id_write),
    .id_ex_write_o      (id_ex_write),
    .if_id_flush_o      (if_id_flush),
    .id_ex_flush_o      (id_ex_flush),
    .ex_mem_flush_o     (ex_mem_flush),
    .forward_a_o        (forward_a),
    .forward_b_o        (forward_b),
    .stall_cnt_o        (stall_cnt),
    .flush_cnt_o        (flush_cnt)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Reference model: phase = cycles elapsed since a long op began (0 = none in flight).
  int phase    = 0;
  int m_stalls = 0;
  int m_flush  = 0;
  bit cnt_valid = 1'b0;
  bit e_pc, e_ifid, e_idex, e_f_ifid, e_f_idex, e_f_exmem;
  int e_fa, e_fb;

  function automatic int fwd_of(input logic [RW-1:0] r, input bit used);
    if (!used || r == 0) return 2;
    if (mem_regwrite && mem_wreg == r) return 0;
    if (wb_regwrite && wb_wreg == r) return 1;
    return 2;
  endfunction

  task automatic model_outputs();
    bit lstall, luse;
    e_pc = 1; e_ifid = 1; e_idex = 1; e_f_ifid = 0; e_f_idex = 0; e_f_exmem = 0;
    e_fa = 2; e_fb = 2;
    if (rst) return;
    e_fa = fwd_of(ex_rs, 1'b1);
    e_fb = fwd_of(ex_rt, ex_uses_rt);
    lstall = (phase == 0 && ex_long && LAT > 1) || (phase >= 1 && phase <= LAT - 2);
    luse = ex_memread && ex_regwrite && ex_wreg != 0 &&
           ((id_uses_rs && ex_wreg == id_rs) || (id_uses_rt && ex_wreg == id_rt));
    if (mem_branch_taken) begin
      e_f_ifid = 1; e_f_idex = 1; e_f_exmem = 1;
    end else if (lstall) begin
      e_pc = 0; e_ifid = 0; e_idex = 0; e_f_exmem = 1;
    end else if (luse) begin
      e_pc = 0; e_ifid = 0; e_f_idex = 1;
    end
  endtask

  task automatic model_advance();
    if (rst) begin
      phase = 0; m_stalls = 0; m_flush = 0; cnt_valid = 1'b1;
      return;
    end
    if (!e_pc && m_stalls < (1 << CW) - 1) m_stalls++;
    if (mem_branch_taken && m_flush < (1 << CW) - 1) m_flush++;
    if (mem_branch_taken) phase = 0;
    else if (phase == 0) phase = (ex_long && LAT > 1) ? 1 : 0;
    else phase = (phase >= LAT - 1) ? 0 : phase + 1;
  endtask

  // Inputs are set just after a falling edge; check, then clock once.
  task automatic cycle();
    #1;
    model_outputs();
    check_eq("pc_write",     pc_write,     e_pc);
    check_eq("if_id_write",  if_id_write,  e_ifid);
    check_eq("id_ex_write",  id_ex_write,  e_idex);
    check_eq("if_id_flush",  if_id_flush,  e_f_ifid);
    check_eq("id_ex_flush",  id_ex_flush,  e_f_idex);
    check_eq("ex_mem_flush", ex_mem_flush, e_f_exmem);
    check_eq("forward_a",    forward_a,    e_fa);
    check_eq("forward_b",    forward_b,    e_fb);
    if (cnt_valid) begin
      check_eq("stall_cnt", stall_cnt, PERF ? m_stalls : 0);
      check_eq("flush_cnt", flush_cnt, PERF ? m_flush : 0);
    end
    @(posedge clk);
    model_advance();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    rst = 0; id_rs = 0; id_rt = 0; ex_rs = 0; ex_rt = 0; ex_wreg = 0; mem_wreg = 0; wb_wreg = 0;
    id_uses_rs = 0; id_uses_rt = 0; ex_uses_rt = 0; ex_memread = 0; ex_regwrite = 0;
    ex_long = 0; mem_regwrite = 0; mem_branch_taken = 0; wb_regwrite = 0;
  endtask

  task automatic random_inputs();
    id_rs = RW'($urandom_range(0, 3)); id_rt = RW'($urandom_range(0, 3));
    ex_rs = RW'($urandom_range(0, 3)); ex_rt = RW'($urandom_range(0, 3));
    ex_wreg = RW'($urandom_range(0, 3)); mem_wreg = RW'($urandom_range(0, 3));
    wb_wreg = RW'($urandom_range(0, 3));
    id_uses_rs = 1'($urandom); id_uses_rt = 1'($urandom); ex_uses_rt = 1'($urandom);
    ex_memread = ($urandom_range(0, 2) == 0); ex_regwrite = 1'($urandom);
    mem_regwrite = 1'($urandom); wb_regwrite = 1'($urandom);
    ex_long = ($urandom_range(0, 7) == 0);
    mem_branch_taken = ($urandom_range(0, 11) == 0);
    rst = ($urandom_range(0, 59) == 0);
  endtask

  initial begin
    clear_inputs();
    rst = 1;
    @(negedge clk);
    cycle();
    cycle();
    rst = 0;

    // Forwarding priority and the r0 exclusion.
    ex_rs = 3; mem_wreg = 3; wb_wreg = 3; mem_regwrite = 1; wb_regwrite = 1;
    #1 check_eq("tp_fwd_a_mem", forward_a, 0);
    cycle();
    ex_rs = 0; mem_wreg = 0; wb_wreg = 0;
    #1 check_eq("tp_fwd_a_r0", forward_a, 2);
    cycle();

    // Load-use: one stall, then the load moves to MEM.
    clear_inputs();
    ex_memread = 1; ex_regwrite = 1; ex_wreg = 8; id_rt = 8; id_uses_rt = 1;
    #1 check_eq("tp_lu_pc", pc_write, 0);
    check_eq("tp_lu_flush", id_ex_flush, 1);
    cycle();
    clear_inputs();
    mem_regwrite = 1; mem_wreg = 8; id_rt = 8; id_uses_rt = 1;
    #1 check_eq("tp_lu_clear", pc_write, 1);
    cycle();

    // Long op: LAT-1 stalls then a release cycle.
    clear_inputs();
    ex_long = 1;
    for (int i = 0; i < LAT; i++) begin
      #1 check_eq("tp_long_pc", pc_write, (i < LAT - 1) ? 0 : 1);
      cycle();
    end
    ex_long = 0;
    cycle();

    // Branch coinciding with a new long op wins; no BUSY entry.
    ex_long = 1; mem_branch_taken = 1;
    #1 check_eq("tp_br_exmem", ex_mem_flush, 1);
    check_eq("tp_br_pc", pc_write, 1);
    cycle();
    ex_long = 0; mem_branch_taken = 0;
    #1 check_eq("tp_br_idle", pc_write, 1);
    cycle();

    // Reset in the middle of a long op.
    ex_long = 1;
    cycle();
    rst = 1;
    cycle();
    rst = 0; ex_long = 0;
    #1 check_eq("tp_rst_idle", id_ex_write, 1);
    check_eq("tp_rst_cnt", stall_cnt, 0);
    cycle();

    // Saturation: a sustained load-use condition for 20 cycles.
    clear_inputs();
    ex_memread = 1; ex_regwrite = 1; ex_wreg = 5; id_rs = 5; id_uses_rs = 1;
    for (int i = 0; i < 20; i++) cycle();
    #1 check_eq("tp_sat", stall_cnt, PERF ? 15 : 0);
    clear_inputs();
    cycle();

    for (int i = 0; i < 3000; i++) begin
      random_inputs();
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Hazard and pipeline-control unit for the 5-stage pipelined CPU. It sits beside the IF/ID, ID/EX and EX/MEM pipeline registers and produces stall, flush and forwarding-select signals. Beyond EX-operand forwarding it detects load-use hazards, flushes on branches resolved in MEM, and stalls for multi-cycle EX operations of parametrised latency. It also keeps optional performance counters.

## Interface
Parameters:
- REG_ADDR_W, 5, register-address width
- MULDIV_LAT, 4, total cycles a long (mul/div) op occupies EX; legal range 1..16
- CNT_W, 32, performance-counter width

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, synchronous, active-high
- id_rs_i, id_rt_i  in  REG_ADDR_W  source registers of the instruction in ID
- id_uses_rs_i, id_uses_rt_i  in  1  ID instruction reads rs / rt
- ex_rs_i, ex_rt_i  in  REG_ADDR_W  source registers held in ID/EX
- ex_uses_rt_i  in  1  EX op takes rt as ALU src2 (0 = immediate)
- ex_memread_i, ex_regwrite_i  in  1  ID/EX control bits
- ex_wreg_i  in  REG_ADDR_W  destination register of the EX op
- ex_long_i  in  1  EX holds a multi-cycle op
- mem_regwrite_i  in  1  EX/MEM RegWrite
- mem_wreg_i  in  REG_ADDR_W  EX/MEM destination register
- mem_branch_taken_i  in  1  branch resolved taken in MEM
- wb_regwrite_i  in  1  MEM/WB RegWrite
- wb_wreg_i  in  REG_ADDR_W  MEM/WB destination register
- pc_write_o, if_id_write_o, id_ex_write_o  out  1  register load enables
- if_id_flush_o, id_ex_flush_o, ex_mem_flush_o  out  1  bubble insertion (load zeros)
- forward_a_o, forward_b_o  out  2  0 = EX/MEM, 1 = MEM/WB, 2 = register file
- stall_cnt_o, flush_cnt_o  out  CNT_W  performance counters

## Operation
- Forwarding is combinational.
  - Operand A: select 0 if mem_regwrite_i and mem_wreg_i == ex_rs_i != 0.
  - Else select 1 if wb_regwrite_i and wb_wreg_i == ex_rs_i != 0.
  - Else select 2.
  - Operand B uses the same rules on ex_rt_i, gated by ex_uses_rt_i; when ex_uses_rt_i = 0 the select is 2.
- Load-use hazard: asserted when ex_memread_i, ex_regwrite_i and ex_wreg_i != 0, and ex_wreg_i matches id_rs_i (with id_uses_rs_i) or id_rt_i (with id_uses_rt_i).
  - Response: pc_write_o = 0, if_id_write_o = 0, id_ex_flush_o = 1, for 1 cycle.
- FSM states: IDLE and BUSY, plus a 4-bit down-counter cnt.
  - IDLE, ex_long_i = 1, MULDIV_LAT > 1: assert a long stall and go to BUSY with cnt = MULDIV_LAT-2.
  - BUSY, cnt > 0: assert a long stall, then cnt--.
  - BUSY, cnt == 0: release cycle (no stall), then go to IDLE.
- Long stall outputs: pc_write_o = 0, if_id_write_o = 0, id_ex_write_o = 0, ex_mem_flush_o = 1.
- Branch flush on mem_branch_taken_i:
  - if_id_flush_o = 1, id_ex_flush_o = 1, ex_mem_flush_o = 1, with pc_write_o = 1.
  - The FSM is forced to IDLE, cnt is cleared and no BUSY entry occurs.
- Priority: branch flush > long stall > load-use. Load-use is suppressed while a long stall is asserted.
- Write enables default to 1 and flushes to 0 when no condition is active.

## Timing
- All control and forward outputs are combinational from the current state and inputs; the FSM, cnt and counters are registered.
- While rst_i is high:
  - write enables read 1, flushes read 0, forward selects read 2;
  - on the next edge the FSM is IDLE, cnt = 0 and both counters are 0.
- A long op with MULDIV_LAT = N gives N-1 stall cycles and a release at cycle N-1 counted from the first ex_long_i cycle. N = 1 gives no stall.
- Reset asserted mid-BUSY aborts the long op; the next cycle is IDLE.
- The load-use stall clears on its own after 1 cycle because the load has advanced to MEM.

## Configuration
- PIPE_HAZARD_PERF_EN defined:
  - stall_cnt_o increments every cycle pc_write_o == 0;
  - flush_cnt_o increments every cycle mem_branch_taken_i == 1;
  - both saturate at all-ones.
- PIPE_HAZARD_PERF_EN undefined: both outputs are tied to 0 and no counter flops exist.

## Structure
- Package pipe_ctrl_pkg holds:
  - forward-select constants FWD_EX_MEM = 2'd0, FWD_MEM_WB = 2'd1, FWD_REG = 2'd2;
  - the FSM state enum (ST_IDLE, ST_BUSY).
- Sub-module fwd_sel is a per-operand combinational forward selector, instantiated twice (A and B).

## Test plan
- Forwarding: ex_rs = 3, mem_wreg = 3, wb_wreg = 3, both regwrites = 1 -> forward_a = 0. Then set mem_wreg = 0 as well as wb_wreg = 0 with ex_rs = 0 -> forward_a = 2.
- Load-use: ex_memread = 1, ex_wreg = 8, id_rt = 8, id_uses_rt = 1 -> exactly 1 cycle of pc_write = 0, if_id_write = 0, id_ex_flush = 1.
- Long op, MULDIV_LAT = 4: ex_long held from t0 -> stall at t0..t2, release at t3, stall_cnt = 3.
- Branch with long op at t0: mem_branch_taken = 1 and ex_long = 1 -> all three flushes = 1, pc_write = 1, FSM stays IDLE, flush_cnt = 1.
- Reset at the t1 BUSY cycle -> the next cycle is IDLE with all write enables 1 and counters 0.
- Counter saturation with CNT_W = 4: 20 stall cycles -> stall_cnt_o holds at 15.
